// File: rtl/oh_round_seq.sv
// One-hot AES round sequencer: initial key add, 10/12/14 rounds, output stage.
// A complemented shadow register and invariant checks raise a sticky alarm that locks it idle.
//   state      | meaning
//   all-zero   | idle, ready for a start
//   bit 0      | initial AddRoundKey
//   bit 1..R   | rounds 1..R, bit R is the final round (last_o, MixColumns bypass)
//   bit NST-1  | output stage (done_o), may overlap with the next start
//   alarm      | forced idle, starts and aborts ignored until reset
module oh_round_seq #(
  parameter int MAX_ROUNDS = 14,
  parameter int NST        = MAX_ROUNDS + 2
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  input  logic           start_i,
  input  logic [1:0]     mode_i,
  input  logic           abort_i,
  output logic [NST-1:0] stage_o,
  output logic           last_o,
  output logic           done_o,
  output logic           ready_o,
  output logic           busy_o,
  output logic           cfg_err_o,
  output logic           alarm_o
);
  localparam int IW = $clog2(NST);
  localparam logic [NST-1:0] ONE = {{(NST-1){1'b0}}, 1'b1};
  localparam logic [NST-1:0] OUT = {1'b1, {(NST-1){1'b0}}};

  logic [NST-1:0] stage_q, stage_d, shadow_q;
  logic [1:0]     mode_q, mode_d;
  logic           alarm_q, alarm_d, cfg_err_q, cfg_err_d;
  logic [IW-1:0]  rounds;
  logic           idle, done, ready, req, fault, range_err;

  // Round counts above MAX_ROUNDS are rejected like the reserved encoding.
  function automatic logic mode_ok(input logic [1:0] m);
    case (m)
      2'd0:    mode_ok = 1'b1;
      2'd1:    mode_ok = (MAX_ROUNDS >= 12);
      2'd2:    mode_ok = (MAX_ROUNDS >= 14);
      default: mode_ok = 1'b0;
    endcase
  endfunction

  always_comb begin
    case (mode_q)
      2'd1:    rounds = (MAX_ROUNDS >= 12) ? IW'(12) : IW'(10);
      2'd2:    rounds = (MAX_ROUNDS >= 14) ? IW'(14) : IW'(10);
      default: rounds = IW'(10);
    endcase
  end

  always_comb begin
    range_err = 1'b0;
    for (int k = 0; k < NST - 1; k++) begin
      if (stage_q[k] && (k > int'(rounds))) range_err = 1'b1;
    end
  end

  assign fault = (stage_q != ~shadow_q)
              || ((stage_q & (stage_q - ONE)) != '0)
              || range_err
              || !mode_ok(mode_q);

  assign idle  = (stage_q == '0);
  assign done  = stage_q[NST-1];
  assign ready = (idle || done) && !alarm_q;
  assign req   = ready && start_i && !abort_i;

  always_comb begin
    stage_d   = '0;
    mode_d    = mode_q;
    alarm_d   = alarm_q || fault;
    cfg_err_d = 1'b0;
    if (!(alarm_q || fault) && !abort_i) begin
      if (req && mode_ok(mode_i)) begin
        stage_d = ONE;
        mode_d  = mode_i;
      end else begin
        cfg_err_d = req;
        // The final round jumps straight to the output slot, skipping unused round bits.
        if (!idle && !done) stage_d = stage_q[rounds] ? OUT : (stage_q << 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stage_q   <= '0;
      shadow_q  <= '1;
      mode_q    <= 2'd0;
      alarm_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      shadow_q  <= ~stage_d;
      mode_q    <= mode_d;
      alarm_q   <= alarm_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign stage_o   = stage_q;
  assign last_o    = stage_q[rounds];
  assign done_o    = done;
  assign ready_o   = ready;
  assign busy_o    = |stage_q[NST-2:0];
  assign cfg_err_o = cfg_err_q;
  assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_oh_round_seq.sv
// Self-checking bench for oh_round_seq: directed scenarios, fault injection and random traffic
// compared each cycle against an operation-level model (active flag, step count, round count).
module tb_oh_round_seq;
  localparam int MAX_ROUNDS = 14;
  localparam int NST        = MAX_ROUNDS + 2;

  logic           clk_i   = 1'b0;
  logic           arst_ni = 1'b1;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [1:0]     mode_i  = 2'd0;
  logic [NST-1:0] stage_o;
  logic           last_o, done_o, ready_o, busy_o, cfg_err_o, alarm_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: an operation is "active" at step 0..R (key add, rounds) or R+1 (output).
  bit m_active, m_alarm, m_cfg;
  int m_step, m_rounds;
  logic [NST-1:0] fval_stage, fval_shadow;
  int lat;

  oh_round_seq #(.MAX_ROUNDS(MAX_ROUNDS)) dut (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .abort_i   (abort_i),
    .stage_o   (stage_o),
    .last_o    (last_o),
    .done_o    (done_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .cfg_err_o (cfg_err_o),
    .alarm_o   (alarm_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkv(input string tag, input logic [NST-1:0] got, input logic [NST-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_alarm  = 1'b0;
    m_cfg    = 1'b0;
    m_step   = 0;
    m_rounds = 10;
  endtask

  function automatic logic [NST-1:0] exp_stage();
    if (!m_active) return '0;
    if (m_step == m_rounds + 1) return NST'(1) << (NST - 1);
    return NST'(1) << m_step;
  endfunction

  task automatic model_edge(input logic s, input logic [1:0] m, input logic a);
    bit dn, rdy;
    dn    = m_active && (m_step == m_rounds + 1);
    rdy   = (!m_active || dn) && !m_alarm;
    m_cfg = rdy && s && !a && (m == 2'd3);
    if (m_alarm || a) m_active = 1'b0;
    else if (rdy && s && (m != 2'd3)) begin
      m_active = 1'b1;
      m_step   = 0;
      m_rounds = 10 + 2 * int'(m);
    end
    else if (dn) m_active = 1'b0;
    else if (m_active) m_step++;
  endtask

  task automatic check_all();
    logic [NST-1:0] es;
    bit ed;
    es = exp_stage();
    ed = m_active && (m_step == m_rounds + 1);
    chkv("stage", stage_o, es);
    chk1("last", last_o, m_active && (m_step == m_rounds));
    chk1("done", done_o, ed);
    chk1("ready", ready_o, (!m_active || ed) && !m_alarm);
    chk1("busy", busy_o, m_active && !ed);
    chk1("cfg_err", cfg_err_o, m_cfg);
    chk1("alarm", alarm_o, m_alarm);
  endtask

  task automatic step(input logic s, input logic [1:0] m, input logic a);
    start_i = s;
    mode_i  = m;
    abort_i = a;
    @(posedge clk_i);
    model_edge(s, m, a);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic do_reset();
    start_i = 1'b0;
    abort_i = 1'b0;
    mode_i  = 2'd0;
    arst_ni = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // 10 rounds: done 11 cycles after stage[0]
    step(1'b1, 2'd0, 1'b0);
    lat = 0;
    while (!done_o && lat < 20) begin
      step(1'b0, 2'd0, 1'b0);
      lat++;
    end
    chkv("latency_r10", NST'(lat), NST'(11));
    step(1'b0, 2'd0, 1'b0);

    // 14 rounds, then back-to-back 12-round start during done_o
    step(1'b1, 2'd2, 1'b0);
    repeat (15) step(1'b0, 2'd0, 1'b0);
    chk1("done_r14", done_o, 1'b1);
    step(1'b1, 2'd1, 1'b0);
    repeat (13) step(1'b0, 2'd0, 1'b0);
    chk1("done_r12", done_o, 1'b1);
    step(1'b0, 2'd0, 1'b0);

    // illegal mode while idle, then start while busy
    step(1'b1, 2'd3, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    repeat (2) step(1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    repeat (9) step(1'b0, 2'd0, 1'b0);

    // abort with simultaneous start at stage[5]
    step(1'b1, 2'd1, 1'b0);
    repeat (5) step(1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd2, 1'b1);
    step(1'b0, 2'd0, 1'b0);

    // asynchronous reset at stage[7]
    step(1'b1, 2'd0, 1'b0);
    repeat (7) step(1'b0, 2'd0, 1'b0);
    #2;
    do_reset();

    // shadow bit flip at stage[3]
    step(1'b1, 2'd0, 1'b0);
    repeat (3) step(1'b0, 2'd0, 1'b0);
    fval_shadow = ~(NST'(1) << 3) ^ NST'(1);
    force dut.shadow_q = fval_shadow;
    @(posedge clk_i);
    #1;
    release dut.shadow_q;
    m_alarm  = 1'b1;
    m_active = 1'b0;
    m_cfg    = 1'b0;
    @(negedge clk_i);
    check_all();
    repeat (4) step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b1);
    do_reset();

    // consistent stage[12] + shadow while latched mode is 10 rounds
    step(1'b1, 2'd0, 1'b0);
    repeat (2) step(1'b0, 2'd0, 1'b0);
    fval_stage  = NST'(1) << 12;
    fval_shadow = ~fval_stage;
    force dut.stage_q  = fval_stage;
    force dut.shadow_q = fval_shadow;
    @(posedge clk_i);
    #1;
    release dut.stage_q;
    release dut.shadow_q;
    m_alarm  = 1'b1;
    m_active = 1'b0;
    m_cfg    = 1'b0;
    @(negedge clk_i);
    chk1("range_alarm", alarm_o, 1'b1);
    chk1("range_ready", ready_o, 1'b0);
    chk1("range_done", done_o, 1'b0);
    repeat (6) step(1'b1, 2'd0, 1'b0);
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, a;
      logic [1:0] m;
      s = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 39) == 0);
      step(s, m, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/oh_round_seq.md
Name: oh_round_seq

Overview:
- Parametrised successor to the team's one-hot control FSM for the AES datapath stages.
- Sequences the initial AddRoundKey, N rounds (10/12/14, selected per operation) and an output stage.
- Provides the start/ready/done handshake and an explicit last-round flag that drives the encoding stage's MixColumns bypass.
- Adds real fault-injection detection: a complemented shadow state register, a one-hot invariant check and a sticky alarm that locks the sequencer.

Parameters:
- MAX_ROUNDS, 14, largest supported round count; must be at least 10.
- NST, MAX_ROUNDS+2, derived; width of the one-hot vector. Index 0 = initial key add, 1..MAX_ROUNDS = rounds, NST-1 = output.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start strobe; accepted only while ready_o=1.
- mode_i  in  2  round count: 0=10, 1=12, 2=14, 3=illegal; sampled with an accepted start.
- abort_i  in  1  cancels the current operation.
- stage_o  out  NST  one-hot state; all-zero when idle.
- last_o  out  1  high during the final round stage; drives MixColumns bypass.
- done_o  out  1  equals stage_o[NST-1].
- ready_o  out  1  the sequencer can accept start_i this cycle.
- busy_o  out  1  stage_o is non-zero and not the output stage.
- cfg_err_o  out  1  one-cycle pulse when a start with mode_i=3 is rejected.
- alarm_o  out  1  sticky fault flag.

Behaviour:
- Reset (async assert, sync release): stage=0, shadow=all-ones, mode register=0, alarm_o=0, cfg_err_o=0, ready_o=1.
- Registers: stage, shadow (intended to equal ~stage), 2-bit mode register, alarm.
- R = 10/12/14 from the mode register.
- Idle is stage==0. An accepted start in cycle t (ready_o=1, mode_i!=3, abort_i=0, no alarm):
  - mode register <= mode_i;
  - stage <= one-hot bit 0 at edge t+1.
- Advance: stage[k] shifts to stage[k+1] for k<R. stage[R] jumps to stage[NST-1], skipping the unused round slots.
  - Latency: start sampled at edge t gives done_o=1 for exactly the cycle after edge t+R+1.
  - Example: R=10 gives done_o 11 cycles after stage[0] was first high.
- last_o = stage[R] using the latched mode. last_o is never high in the same cycle as stage[NST-1].
- Output stage: the next state is idle, or bit 0 if a new start is accepted in the same cycle (first/last overlap, back-to-back). A new start's mode takes effect immediately.
- ready_o is combinational: (idle or done_o) and not alarm_o. busy_o = |stage[NST-2:0].
- start_i while not ready: ignored, no error.
- mode_i=3 with an otherwise-acceptable start: no state change; cfg_err_o=1 on the next cycle.
- abort_i=1: stage <= 0 next edge, no done_o. Abort wins over a simultaneous start; an abort during the output stage suppresses a restart.
- Fault detection, evaluated every cycle; any condition sets alarm (sticky until reset):
  - stage != ~shadow;
  - more than one bit of stage set;
  - a bit set above index R other than NST-1;
  - mode register == 3.
- Once alarm=1:
  - stage <= 0 and shadow <= all-ones on the next edge, and both stay there;
  - ready_o=0; start_i and abort_i are ignored;
  - done_o is never asserted from the faulted operation.
- Reset mid-operation: all registers return to reset values immediately, asynchronously.
- No combinational path from start_i to stage_o. ready_o may depend combinationally on state only.

Test Plan:
- Reset, then start with mode_i=0 at edge t: stage_o walks bits 0..10; last_o high with bit 10; done_o high one cycle at t+12; ready_o low from t+1 to t+11.
- mode_i=2 (14 rounds), with start re-asserted during done_o and mode_i=1: done_o at t+16; the next operation's stage[0] follows with no idle cycle; the second done_o comes 13 cycles later, with last_o at stage[12].
- start with mode_i=3 while idle -> stage_o stays 0, cfg_err_o pulses 1 cycle, ready_o stays 1. start while busy -> ignored; the sequence is unchanged.
- abort_i at stage[5] together with start_i -> stage_o=0 next cycle, no done_o, ready_o=1. arst_ni low at stage[7] -> outputs at reset values immediately.
- Force a bit flip in shadow (or a second stage bit) at stage[3] -> alarm_o=1 next edge, stage_o=0, ready_o=0. Subsequent starts are ignored; alarm_o clears only on arst_ni.
- Force stage[12] while the latched mode is 10 rounds -> alarm_o=1, and done_o is never asserted.
